// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder and imem loader.
// Takes one decoded instruction per cycle and encodes it to a 32-bit word.
// It rejects out-of-range immediates and queues legal words in a small FIFO.
// Words drain into instruction memory at an auto-incrementing word address.
module inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_wen,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [4:0]        err_op,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [4:0] {
    OP_NOP, OP_LW, OP_SW, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_ANDI, OP_ORI, OP_XORI, OP_SLL, OP_SRL, OP_SRA, OP_SLLI,
    OP_SRLI, OP_SRAI, OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE,
    OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  } op_e;

  // Instruction format; shift-immediates get their own kind for the 0..31 check.
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_NOP
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] word;
  logic        legal;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic [ADDR_W-1:0] addr_q;
  logic             full, push, pop, reject;

  // Map the operation index to format, opcode, funct3 and funct7.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    fmt    = FMT_R;
    opcode = 7'h33;
    funct3 = 3'd0;
    funct7 = 7'h00;
    case (op_e'(in_op))
      OP_NOP:   fmt = FMT_NOP;
      OP_LW:    begin fmt = FMT_I; opcode = 7'h03; funct3 = 3'd2; end
      OP_SW:    begin fmt = FMT_S; opcode = 7'h23; funct3 = 3'd2; end
      OP_ADD:   funct3 = 3'd0;
      OP_SUB:   begin funct3 = 3'd0; funct7 = 7'h20; end
      OP_AND:   funct3 = 3'd7;
      OP_OR:    funct3 = 3'd6;
      OP_XOR:   funct3 = 3'd4;
      OP_SLL:   funct3 = 3'd1;
      OP_SRL:   funct3 = 3'd5;
      OP_SRA:   begin funct3 = 3'd5; funct7 = 7'h20; end
      OP_SLT:   funct3 = 3'd2;
      OP_SLTU:  funct3 = 3'd3;
      OP_ADDI:  begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd0; end
      OP_ANDI:  begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd7; end
      OP_ORI:   begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd6; end
      OP_XORI:  begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd4; end
      OP_SLTI:  begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd2; end
      OP_SLTIU: begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd3; end
      OP_SLLI:  begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd1; end
      OP_SRLI:  begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd5; end
      OP_SRAI:  begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd5; funct7 = 7'h20; end
      OP_BEQ:   begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd0; end
      OP_BNE:   begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd1; end
      OP_BLT:   begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd4; end
      OP_BGE:   begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd5; end
      OP_BLTU:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd6; end
      OP_BGEU:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd7; end
      OP_JAL:   begin fmt = FMT_J; opcode = 7'h6F; end
      OP_JALR:  begin fmt = FMT_I; opcode = 7'h67; funct3 = 3'd0; end
      OP_LUI:   begin fmt = FMT_U; opcode = 7'h37; end
      OP_AUIPC: begin fmt = FMT_U; opcode = 7'h17; end
      default:  fmt = FMT_R;
    endcase
  end

  // Assemble the word and check the immediate fits the field it lands in.
  // Sign-extension checks: all bits above the field's sign bit must agree.
  always_comb begin
    word  = 32'h0000_0013;
    legal = 1'b1;
    case (fmt)
      FMT_R:  word = {funct7, in_rs2, in_rs1, funct3, in_rd, opcode};
      FMT_I: begin
        word  = {in_imm[11:0], in_rs1, funct3, in_rd, opcode};
        legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      FMT_SH: begin
        word  = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, opcode};
        legal = ~(|in_imm[31:5]);
      end
      FMT_S: begin
        word  = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], opcode};
        legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      FMT_B: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                 in_imm[4:1], in_imm[11], opcode};
        legal = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
      end
      FMT_J: begin
        word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode};
        legal = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
      end
      FMT_U: begin
        word  = {in_imm[31:12], in_rd, opcode};
        legal = ~(|in_imm[11:0]);
      end
      default: word = 32'h0000_0013;
    endcase
  end

  // Handshake and FIFO control; clear suppresses both push and pop.
  always_comb begin
    full     = (occ == (PTR_W+1)'(DEPTH));
    in_ready = ~full;
    push     = in_valid & in_ready & legal & ~clear;
    reject   = in_valid & in_ready & ~legal & ~clear;
    imem_wen = (occ != '0);
    busy     = imem_wen;
    pop      = imem_wen & imem_ready & ~clear;
    imem_addr  = addr_q;
    imem_wdata = mem[rd_ptr];
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; only the pointers and occupancy
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // Pointers, occupancy, write address, written-word count and error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      addr_q <= ADDR_W'(BASE_ADDR);
      count  <= '0;
      err    <= 1'b0;
      err_op <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      addr_q <= ADDR_W'(BASE_ADDR);
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
        if (count != '1) count <= count + (ADDR_W+1)'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
      if (reject) begin
        err <= 1'b1;
        if (!err) err_op <= in_op;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, backpressure, illegal
// immediates, address wrap (second instance with a 2-bit address), clear
// and asynchronous reset.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, imem_ready;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, imem_wen, err, busy;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] count;
  logic [4:0]  err_op;

  logic        w_in_ready, w_wen, w_err, w_busy;
  logic [1:0]  w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_count;
  logic [4:0]  w_err_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .imem_wen(imem_wen),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .err(err), .err_op(err_op), .busy(busy)
  );

  inst_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(w_in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .imem_wen(w_wen),
    .imem_ready(imem_ready), .imem_addr(w_addr), .imem_wdata(w_wdata),
    .count(w_count), .err(w_err), .err_op(w_err_op), .busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic push(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    set_in(op, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Head entry must be presented at the given address; it retires on the next edge.
  task automatic drain(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, ".wen"}, {31'd0, imem_wen}, 32'd1);
    check({tag, ".addr"}, {22'd0, imem_addr}, addr);
    check({tag, ".data"}, imem_wdata, data);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step(); step();

    // Reset state
    check("rst.wen",      {31'd0, imem_wen}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.addr",     {22'd0, imem_addr}, 32'd0);
    check("rst.count",    {21'd0, count}, 32'd0);
    check("rst.err",      {31'd0, err}, 32'd0);
    check("rst.err_op",   {27'd0, err_op}, 32'd0);
    check("rst.busy",     {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic encodings, queued under stall then drained
    push(5'd4, 5'd1, 5'd0, 5'd0, 32'd5);                 // ADDI x1,x0,5
    check("addi.lat.wen",  {31'd0, imem_wen}, 32'd1);
    check("addi.lat.data", imem_wdata, 32'h0050_0093);
    push(5'd3, 5'd3, 5'd1, 5'd2, 32'd0);                 // ADD x3,x1,x2
    push(5'd2, 5'd0, 5'd1, 5'd2, 32'd8);                 // SW x2,8(x1)
    check("stall1.addr", {22'd0, imem_addr}, 32'd0);
    check("stall1.data", imem_wdata, 32'h0050_0093);
    check("stall1.in_ready", {31'd0, in_ready}, 32'd1);
    imem_ready = 1'b1;
    drain("addi", 32'd0, 32'h0050_0093);
    drain("add",  32'd1, 32'h0020_81B3);
    drain("sw",   32'd2, 32'h0020_A423);
    check("enc.count", {21'd0, count}, 32'd3);
    check("enc.idle",  {31'd0, imem_wen}, 32'd0);

    // Backpressure: fill the FIFO, hold a fifth request
    imem_ready = 1'b0;
    push(5'd22, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);        // BEQ x1,x2,-4
    push(5'd28, 5'd1, 5'd0, 5'd0, 32'd8);                // JAL x1,+8
    push(5'd30, 5'd5, 5'd0, 5'd0, 32'h1234_5000);        // LUI x5,0x12345
    push(5'd17, 5'd1, 5'd1, 5'd0, 32'd3);                // SRAI x1,x1,3
    check("full.in_ready", {31'd0, in_ready}, 32'd0);
    set_in(5'd8, 5'd4, 5'd1, 5'd2, 32'd0);               // XOR x4,x1,x2
    in_valid = 1'b1;
    step();
    check("hold1.addr", {22'd0, imem_addr}, 32'd3);
    check("hold1.data", imem_wdata, 32'hFE20_8EE3);
    step();
    check("hold2.addr", {22'd0, imem_addr}, 32'd3);
    check("hold2.data", imem_wdata, 32'hFE20_8EE3);
    check("hold2.in_ready", {31'd0, in_ready}, 32'd0);
    imem_ready = 1'b1;
    drain("beq", 32'd3, 32'hFE20_8EE3);
    check("unfull.in_ready", {31'd0, in_ready}, 32'd1);
    drain("jal", 32'd4, 32'h0080_00EF);                  // XOR pushed on this edge
    in_valid = 1'b0;
    drain("lui",  32'd5, 32'h1234_52B7);
    drain("srai", 32'd6, 32'h4030_D093);
    drain("xor",  32'd7, 32'h0020_C233);
    check("bp.count", {21'd0, count}, 32'd8);
    check("bp.idle",  {31'd0, imem_wen}, 32'd0);

    // Illegal immediates: first error latches err_op
    push(5'd4, 5'd1, 5'd0, 5'd0, 32'd2048);              // ADDI imm=2048
    check("ill1.wen",    {31'd0, imem_wen}, 32'd0);
    check("ill1.err",    {31'd0, err}, 32'd1);
    check("ill1.err_op", {27'd0, err_op}, 32'd4);
    check("ill1.in_ready", {31'd0, in_ready}, 32'd1);
    push(5'd22, 5'd0, 5'd1, 5'd2, 32'd3);                // BEQ imm=3
    check("ill2.wen",    {31'd0, imem_wen}, 32'd0);
    check("ill2.err_op", {27'd0, err_op}, 32'd4);
    push(5'd4, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF);         // ADDI x2,x0,-1
    drain("addi_m1", 32'd8, 32'hFFF0_0113);
    push(5'd5, 5'd5, 5'd6, 5'd7, 32'd0);                 // SUB x5,x6,x7
    drain("sub", 32'd9, 32'h4073_02B3);
    push(5'd15, 5'd1, 5'd1, 5'd0, 32'd31);               // SLLI x1,x1,31
    drain("slli31", 32'd10, 32'h01F0_9093);
    push(5'd0, 5'd7, 5'd7, 5'd7, 32'd123);               // NOP ignores fields
    drain("nop", 32'd11, 32'h0000_0013);
    push(5'd4, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);         // ADDI imm=-2048
    drain("addi_min", 32'd12, 32'h8000_0093);
    check("ill.count", {21'd0, count}, 32'd13);
    check("ill.err_sticky", {31'd0, err}, 32'd1);

    // Clear, then address wrap on the 2-bit instance
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr.addr",  {22'd0, imem_addr}, 32'd0);
    check("clr.count", {21'd0, count}, 32'd0);
    check("clr.err",   {31'd0, err}, 32'd0);
    check("clr.w_addr", {30'd0, w_addr}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      push(5'd4, 5'd1, 5'd0, 5'd0, i);
      check($sformatf("wrap%0d.wen", i),  {31'd0, w_wen}, 32'd1);
      check($sformatf("wrap%0d.addr", i), {30'd0, w_addr}, i % 4);
      check($sformatf("wrap%0d.data", i), w_wdata, (i << 20) | 32'h93);
    end
    step();
    check("wrap.count", {29'd0, w_count}, 32'd5);
    check("wrap.idle",  {31'd0, w_wen}, 32'd0);
    check("wrap.main_addr", {22'd0, imem_addr}, 32'd5);

    // clear together with a valid push flushes everything
    push(5'd4, 5'd1, 5'd0, 5'd0, 32'd4096);              // illegal: sets err
    check("pre_clr.err", {31'd0, err}, 32'd1);
    imem_ready = 1'b0;
    push(5'd3, 5'd1, 5'd2, 5'd3, 32'd0);
    push(5'd3, 5'd4, 5'd5, 5'd6, 32'd0);
    check("pre_clr.busy", {31'd0, busy}, 32'd1);
    set_in(5'd3, 5'd7, 5'd8, 5'd9, 32'd0);
    in_valid = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr2.busy",  {31'd0, busy}, 32'd0);
    check("clr2.wen",   {31'd0, imem_wen}, 32'd0);
    check("clr2.addr",  {22'd0, imem_addr}, 32'd0);
    check("clr2.count", {21'd0, count}, 32'd0);
    check("clr2.err",   {31'd0, err}, 32'd0);
    check("clr2.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("clr2.lost", {31'd0, imem_wen}, 32'd0);

    // Asynchronous reset in the middle of a stall
    imem_ready = 1'b1;
    push(5'd4, 5'd1, 5'd0, 5'd0, 32'd7);
    drain("pre_rst", 32'd0, 32'h0070_0093);
    imem_ready = 1'b0;
    push(5'd3, 5'd1, 5'd2, 5'd3, 32'd0);
    push(5'd3, 5'd4, 5'd5, 5'd6, 32'd0);
    push(5'd3, 5'd7, 5'd8, 5'd9, 32'd0);
    check("pre_rst.count", {21'd0, count}, 32'd1);
    check("pre_rst.busy",  {31'd0, busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.wen",      {31'd0, imem_wen}, 32'd0);
    check("arst.in_ready", {31'd0, in_ready}, 32'd1);
    check("arst.count",    {21'd0, count}, 32'd0);
    check("arst.addr",     {22'd0, imem_addr}, 32'd0);
    check("arst.busy",     {31'd0, busy}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("post_rst.wen", {31'd0, imem_wen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Streaming RV32I instruction encoder and instruction-memory loader, the inverse of the pipeline's instruction decoder.
- Accepts one decoded instruction per cycle (operation, register addresses, immediate) over a valid/ready handshake.
- Encodes it to a 32-bit RV32I word and range-checks the immediate.
- Buffers the word in a small FIFO, then writes it to instruction memory at an auto-incrementing word address.
- Used by the boot loader and testbenches to build programs in imem.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 10, imem word-address width
BASE_ADDR, 0, first word address after reset or clear

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush: empty FIFO, addr<=BASE_ADDR, count<=0, err cleared
in_valid  in  1  request valid
in_ready  out  1  FIFO can accept
in_op  in  5  operation index (see Behaviour)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate, same form as decoder imm output (U-type = full upper value, B/J = byte offset)
imem_wen  out  1  write request = FIFO non-empty
imem_ready  in  1  imem accepts write this cycle
imem_addr  out  ADDR_W  word address of head entry
imem_wdata  out  32  encoded head word
count  out  ADDR_W+1  words written since reset/clear, saturating
err  out  1  sticky: an instruction was rejected
err_op  out  5  in_op of first rejected instruction
busy  out  1  FIFO non-empty

Behaviour:
- Reset: applied asynchronously on rst_n low. Outputs: FIFO empty, imem_wen=0, imem_addr=BASE_ADDR, count=0, err=0, err_op=0, in_ready=1, busy=0.
- in_op indices and encodings:
  - 0 NOP, 1 LW, 2 SW, 3 ADD, 4 ADDI, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 ANDI, 10 ORI, 11 XORI
  - 12 SLL, 13 SRL, 14 SRA, 15 SLLI, 16 SRLI, 17 SRAI, 18 SLT, 19 SLTU, 20 SLTI, 21 SLTIU
  - 22 BEQ, 23 BNE, 24 BLT, 25 BGE, 26 BLTU, 27 BGEU, 28 JAL, 29 JALR, 30 LUI, 31 AUIPC
  - All use standard RV32I base opcode/funct3/funct7 encodings.
  - NOP encodes 0x00000013.
  - SUB, SRA, SRAI set funct7=0x20.
- Field usage: unused register fields are encoded as 0 (e.g. LUI rs1/rs2, I-type rs2).
- Immediate legality (signed = two's complement of in_imm):
  - I/S-type (LW, SW, ADDI, ANDI, ORI, XORI, SLTI, SLTIU, JALR): -2048..2047.
  - SLLI/SRLI/SRAI: 0..31.
  - B-type: -4096..4094 and bit0=0.
  - JAL: -1048576..1048574 and bit0=0.
  - LUI/AUIPC: in_imm[11:0]=0.
  - R-type and NOP ignore in_imm.
- Handshake:
  - Transfer occurs when in_valid & in_ready.
  - in_ready = !full. It is independent of imem_ready, so there is no pass-through when full.
  - Encoding and check are combinational on the inputs; the legal word is pushed at the same clock edge.
- Rejected instruction:
  - Nothing is pushed and the address is not consumed.
  - err<=1. err_op is loaded only if err was 0.
  - in_ready is unaffected.
- Latency: word accepted at edge N gives imem_wen=1 with that word from cycle N+1, if the FIFO was empty.
- Write completion:
  - A write completes on an edge with imem_wen & imem_ready.
  - It pops the head, increments imem_addr (mod 2^ADDR_W, wraps silently) and increments count (saturates at all-ones).
- Write stall: imem_addr and imem_wdata hold stable while imem_wen=1 and imem_ready=0.
- Push and pop on the same edge: both are allowed. Occupancy is unchanged. When full, a push is impossible because in_ready=0.
- FIFO: strict order, no drops.
- clear has priority over push and pop on the same edge. An in-flight handshake in that cycle is discarded.
- rst_n asserted mid-transfer: all state is lost immediately, with the reset values above.

Test Plan:
- Encoding:
  - ADDI x1,x0,5 -> 0x00500093 at addr 0.
  - ADD x3,x1,x2 -> 0x002081B3 at addr 1.
  - SW x2,8(x1) -> 0x0020A423 at addr 2.
  - Then count=3.
- Branch/jump/upper:
  - BEQ x1,x2,-4 -> 0xFE208EE3.
  - JAL x1,+8 -> 0x008000EF.
  - LUI x5,0x12345000 -> 0x123452B7.
  - SRAI x1,x1,3 -> 0x4030D093.
- Backpressure:
  - imem_ready=0 while pushing 5 words with DEPTH=4 -> in_ready=0 after the 4th push, addr/data stable.
  - Then imem_ready=1 -> 4 writes in order on consecutive cycles, followed by the 5th.
- Illegal immediate:
  - ADDI imm=2048 -> no write, err=1, err_op=4.
  - Then BEQ imm=3 -> still err_op=4.
  - Next legal word goes to the unchanged address.
- Wrap and clear:
  - ADDR_W=2: 5 writes -> addresses 0,1,2,3,0.
  - clear asserted together with a valid push -> FIFO empty, addr=BASE_ADDR, count=0, err=0, pushed word lost.
- Async reset: rst_n low mid-stall with 3 queued words -> imem_wen=0 immediately, in_ready=1, count=0.
